// File: rtl/mem_copy_engine.sv
// Small DMA that copies LEN consecutive words from src to dst over a single-port memory.
// Optional running checksum of the written words is enabled by defining CHECKSUM_EN.
module mem_copy_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  output logic              memWrite,
  input  logic [DATA_W-1:0] readData
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  words_done_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] writeData_q;
  logic              memWrite_q, busy_q, done_q;
  logic [DATA_W-1:0] csum_q;

  logic [LEN_W-1:0]  idx_d;
  logic              last_d;

  assign idx_d  = idx_q + LEN_W'(1);
  assign last_d = (idx_q == len_q - LEN_W'(1));

  // Transfer descriptor: only meaningful once a start is accepted, so no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      src_q <= src_addr;
      dst_q <= dst_addr;
      len_q <= length;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      words_done_q <= '0;
      address_q    <= '0;
      writeData_q  <= '0;
      memWrite_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      csum_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q        <= '0;
            words_done_q <= '0;
            csum_q       <= '0;
            if (length != '0) begin
              state_q   <= READ;
              busy_q    <= 1'b1;
              address_q <= src_addr;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        READ: begin
          // writeData_q doubles as the word buffer between the read and the write.
          state_q     <= WRITE;
          address_q   <= dst_q + ADDR_W'(idx_q);
          writeData_q <= readData;
          memWrite_q  <= 1'b1;
        end
        WRITE: begin
          memWrite_q   <= 1'b0;
          words_done_q <= words_done_q + LEN_W'(1);
          csum_q       <= csum_q + writeData_q;
          if (last_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q     <= idx_d;
            address_q <= src_q + ADDR_W'(idx_d);
            state_q   <= READ;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = words_done_q;
  assign address    = address_q;
  assign writeData  = writeData_q;
  assign memWrite   = memWrite_q;

`ifdef CHECKSUM_EN
  assign checksum = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine with a 64-word behavioural memory aliased on address[5:0].
// Expected writes and completions are queued by the stimulus; a negedge monitor checks them.
module tb_mem_copy_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] length;
  logic        busy, done, memWrite;
  logic [15:0] words_done;
  logic [31:0] address, writeData, readData;
`ifdef CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] mem [0:63];
  logic        ld_we;
  logic [5:0]  ld_a;
  logic [31:0] ld_d;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [15:0] wd; logic [31:0] cs; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  wr_t w;
  dn_t dd;
  logic prev_we;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .words_done(words_done),
    .address(address), .writeData(writeData), .memWrite(memWrite),
    .readData(readData)
`ifdef CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  assign readData = mem[address[5:0]];

  always @(posedge clk) begin
    if (memWrite) mem[address[5:0]] <= writeData;
    else if (ld_we) mem[ld_a] <= ld_d;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (memWrite) begin
        chk("we_gap", {63'd0, prev_we}, 64'd0);
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual=%0h:%0h required=none", address, writeData);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", {32'd0, address}, {32'd0, w.a});
          chk("wr_data", {32'd0, writeData}, {32'd0, w.d});
        end
      end
      if (done) begin
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          dd = dq.pop_front();
          chk("words_done", {48'd0, words_done}, {48'd0, dd.wd});
`ifdef CHECKSUM_EN
          chk("checksum", {32'd0, checksum}, {32'd0, dd.cs});
`endif
        end
      end
      prev_we <= memWrite;
    end else begin
      prev_we <= 1'b0;
    end
  end

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_a = a; ld_d = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic push_w(input logic [31:0] a, input logic [31:0] d);
    wr_t t;
    t.a = a; t.d = d;
    wq.push_back(t);
  endtask

  task automatic push_d(input logic [15:0] wd, input logic [31:0] cs);
    dn_t t;
    t.wd = wd; t.cs = cs;
    dq.push_back(t);
  endtask

  // Starts a copy and waits (bounded) for done; pulse_at>0 re-pulses start in that cycle.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input int exp_cyc, input bit busy_low, input int pulse_at);
    int  cyc;
    bit  got;
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (busy_low) chk("busy_len0", {63'd0, busy}, 64'd0);
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
        if (cyc == pulse_at) begin
          start = 1'b1; src_addr = 32'd7; dst_addr = 32'd50; length = 16'd1;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=none required=%0d", exp_cyc);
    end else begin
      chk("done_cycle", cyc, exp_cyc);
    end
    @(posedge clk); #1;
    chk("words_done_hold", {48'd0, words_done}, {48'd0, n});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    ld_we = 1'b0; ld_a = '0; ld_d = '0;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_we", {63'd0, memWrite}, 64'd0);
    chk("rst_addr", {32'd0, address}, 64'd0);
    chk("rst_wdata", {32'd0, writeData}, 64'd0);
    chk("rst_words", {48'd0, words_done}, 64'd0);
`ifdef CHECKSUM_EN
    chk("rst_csum", {32'd0, checksum}, 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic 4-word copy
    for (int i = 0; i < 4; i++) load(6'(i), 32'(i + 1));
    for (int i = 0; i < 4; i++) push_w(32'(16 + i), 32'(i + 1));
    push_d(16'd4, 32'd10);
    run(32'd0, 32'd16, 16'd4, 9, 1'b0, 0);
    for (int i = 0; i < 4; i++) chk("mem_basic", {32'd0, mem[16 + i]}, 64'(i + 1));

    // Zero length
    push_d(16'd0, 32'd0);
    run(32'd5, 32'd9, 16'd0, 1, 1'b1, 0);

    // Address wrap at the top of the space
    load(6'd62, 32'd7); load(6'd63, 32'd8); load(6'd0, 32'd9);
    push_w(32'd8, 32'd7); push_w(32'd9, 32'd8); push_w(32'd10, 32'd9);
    push_d(16'd3, 32'd24);
    run(32'hFFFF_FFFE, 32'd8, 16'd3, 7, 1'b0, 0);
    chk("mem_wrap0", {32'd0, mem[8]}, 64'd7);
    chk("mem_wrap1", {32'd0, mem[9]}, 64'd8);
    chk("mem_wrap2", {32'd0, mem[10]}, 64'd9);

    // Overlapping forward copy replicates the leading word
    load(6'd0, 32'd5); load(6'd1, 32'd6); load(6'd2, 32'd7);
    push_w(32'd1, 32'd5); push_w(32'd2, 32'd5);
    push_d(16'd2, 32'd10);
    run(32'd0, 32'd1, 16'd2, 5, 1'b0, 0);
    chk("mem_ovl1", {32'd0, mem[1]}, 64'd5);
    chk("mem_ovl2", {32'd0, mem[2]}, 64'd5);

    // Start re-pulsed mid-transfer is ignored
    for (int i = 0; i < 4; i++) load(6'(i), 32'(i + 1));
    for (int i = 0; i < 4; i++) push_w(32'(32 + i), 32'(i + 1));
    push_d(16'd4, 32'd10);
    run(32'd0, 32'd32, 16'd4, 9, 1'b0, 3);
    repeat (3) @(posedge clk);
    #1;

    // Reset during the second write
    load(6'd42, 32'hAA); load(6'd43, 32'hBB); load(6'd41, 32'hCC);
    push_w(32'd40, 32'd1);
    src_addr = 32'd0; dst_addr = 32'd40; length = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("we_before_rst", {63'd0, memWrite}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", {63'd0, memWrite}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mem_rst40", {32'd0, mem[40]}, 64'd1);
    chk("mem_rst42", {32'd0, mem[42]}, 64'hAA);
    chk("mem_rst43", {32'd0, mem[43]}, 64'hBB);

    // Engine is back in IDLE and accepts a new copy
    push_w(32'd50, 32'd1);
    push_d(16'd1, 32'd1);
    run(32'd0, 32'd50, 16'd1, 3, 1'b0, 0);

    repeat (2) @(posedge clk);
    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("dq_empty", 64'(dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
